sonar_ranger: RTL and testbench
===============================

Name: sonar_ranger

Overview:
- Ultrasonic ranging engine for an HC-SR04-class sensor. It sits beside the servo sweep controller.
- On request it fires a trigger pulse, times the echo, converts the echo width to whole inches and presents the result with a one-cycle valid strobe.
- The sweep controller issues do_measure at each servo step. It consumes inches/valid for target detection and the LED display.

Parameters:
- CLK_HZ, 100_000_000: input clock frequency; must be an integer multiple of 1_000_000.
- TRIG_US, 10: trigger pulse width in microseconds.
- US_PER_INCH, 148: echo microseconds per inch (round trip).
- TIMEOUT_US, 38000: maximum wait for echo rise, and maximum echo high time.
- HOLDOFF_US, 60000: minimum gap from measurement end to the next trigger.
- INCH_W, 9: width of the inches result.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- do_measure  in  1  level request; sampled only in IDLE.
- sonar_pulse  in  1  echo input from the sensor; asynchronous.
- sonar_trigger  out  1  trigger to the sensor.
- inches  out  INCH_W  last measured distance.
- valid  out  1  one-cycle strobe when inches/timeout are updated.
- timeout  out  1  last measurement failed; valid with valid.
- ready  out  1  high only in IDLE.

Behaviour:
Reset values:
- All outputs at reset: sonar_trigger=0, inches=0, valid=0, timeout=0, ready=0 during reset, then ready=1 on the first clk after release.
- Reset clears state, counters, synchronizer and prescaler.
- Reset asserted mid-operation aborts immediately: trigger drops asynchronously and no valid is issued.

Timebase and echo input:
- A prescaler produces us_tick, a one-cycle pulse every CLK_HZ/1e6 clocks, free-running from reset.
- sonar_pulse passes through a 2-FF synchronizer, then a registered copy for edge detect. Rise/fall detection latency is 3 clk.

FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF.
- IDLE: ready=1. If do_measure=1, go to TRIG next cycle and clear the us counter. do_measure is ignored in every other state.
- TRIG: sonar_trigger=1 for exactly TRIG_US*CLK_HZ/1e6 clocks, counted in clk cycles rather than ticks. Then go to WAIT_RISE with the counter cleared.
- WAIT_RISE: on echo rising edge, go to MEASURE and clear the us counter and inches accumulator. If the counter reaches TIMEOUT_US first, take the timeout exit.
- MEASURE: on each us_tick, increment the sub-inch counter. When it equals US_PER_INCH-1, wrap it to 0 and increment the inch accumulator.
  - The accumulator saturates at 2^INCH_W-1; it never wraps.
  - On echo falling edge: load inches with the accumulator, pulse valid=1 with timeout=0 for one cycle, go to HOLDOFF.
  - If echo stays high TIMEOUT_US, take the timeout exit.
- Timeout exit: inches holds its previous value, timeout=1, valid=1 for one cycle, go to HOLDOFF.
- HOLDOFF: wait HOLDOFF_US ticks, then go to IDLE. An echo edge here is ignored.
- Result: inches = floor(echo_us/US_PER_INCH), with ±1 us tick-alignment jitter.
- timeout remains at its last value between valid strobes.
- Simultaneous echo fall and timeout count in the same cycle: the echo fall wins (normal result).
- An echo already high on entry to WAIT_RISE is not an edge; the block waits for low followed by high.
- If do_measure is held high continuously, measurements repeat at a period of trigger + echo/timeout + holdoff.

Optional Feature:
SONAR_AVG_EN
- Defined: inches reports the mean of the last 4 successful results, computed as (sum of 4)>>2 with a sum width of INCH_W+2.
  - After reset, the first successful result fills all 4 history entries.
  - Timeout results do not enter the history.
  - valid timing is unchanged; the average is registered in the same cycle as the valid strobe.
- Undefined: inches is the raw single measurement as described above.

Test Plan:
- Reset: hold rst, then release → ready=1, trigger=0, inches=0, valid=0; then pulse do_measure → sonar_trigger high for exactly 1000 clk at 100 MHz.
- Normal measurement: echo high 1480 us, starting 200 us after trigger fall → one valid pulse, inches=10, timeout=0; the next trigger is no earlier than 60000 us after valid.
- Boundary: echo 1479 us → inches=9; echo 1628 us → inches=11.
- No echo → valid 38000 us (±1) after trigger fall, timeout=1, inches holds its prior value 10.
- Stuck echo (high 50000 us) → timeout=1 at 38000 us into MEASURE; an echo fall in HOLDOFF produces no second valid.
- Reset mid-MEASURE, then do_measure → no valid from the aborted run; with SONAR_AVG_EN, results 10, 20, 30, 40 yield inches 10, 12, 17, 25.

Source files
------------

// File: rtl/sonar_ranger_if.sv
// sonar_ranger_if: groups the request, echo and result signals of the
// ultrasonic ranging engine.
//   do_measure    : level request from the sweep controller
//   sonar_pulse   : raw echo line from the sensor (asynchronous)
//   sonar_trigger : trigger pulse to the sensor
//   inches        : last measured distance
//   valid         : one-cycle strobe when inches/timeout update
//   timeout       : last measurement failed
//   ready         : engine idle and accepting do_measure
// master = sweep controller / sensor side, slave = sonar_ranger.
interface sonar_ranger_if #(
    parameter int INCH_W = 9
);
    logic              do_measure;
    logic              sonar_pulse;
    logic              sonar_trigger;
    logic [INCH_W-1:0] inches;
    logic              valid;
    logic              timeout;
    logic              ready;

    modport master (
        output do_measure, sonar_pulse,
        input  sonar_trigger, inches, valid, timeout, ready
    );

    modport slave (
        input  do_measure, sonar_pulse,
        output sonar_trigger, inches, valid, timeout, ready
    );
endinterface

// File: rtl/sonar_ranger.sv
// sonar_ranger: HC-SR04-class ranging engine. On do_measure it fires a
// trigger pulse, times the echo in microseconds, converts it to whole
// inches (saturating) and strobes valid for one cycle. No echo rise, or an
// echo held high too long, ends in a timeout result. A holdoff gap
// separates consecutive measurements.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : sonar_ranger_if.slave (do_measure, sonar_pulse in;
//              sonar_trigger, inches, valid, timeout, ready out)
// Optional feature macro SONAR_AVG_EN: when defined, inches reports the
// mean of the last 4 successful results instead of the raw measurement.
module sonar_ranger #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TRIG_US     = 10,
    parameter int US_PER_INCH = 148,
    parameter int TIMEOUT_US  = 38000,
    parameter int HOLDOFF_US  = 60000,
    parameter int INCH_W      = 9
) (
    input logic          clk,
    input logic          rst,
    sonar_ranger_if.slave bus
);
    localparam int CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int TRIG_CYC   = TRIG_US * CYC_PER_US;
    localparam int CNT_MAX0   = (TRIG_CYC > TIMEOUT_US) ? TRIG_CYC : TIMEOUT_US;
    localparam int CNT_MAX    = (CNT_MAX0 > HOLDOFF_US) ? CNT_MAX0 : HOLDOFF_US;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int PSC_W      = (CYC_PER_US > 1) ? $clog2(CYC_PER_US) : 1;
    localparam int SUB_W      = (US_PER_INCH > 1) ? $clog2(US_PER_INCH) : 1;
    localparam logic [INCH_W-1:0] INCH_MAX = '1;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

    state_t            state_q, state_d;
    logic [PSC_W-1:0]  psc_q;
    logic [2:0]        sync_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUB_W-1:0]  sub_q, sub_d, sub_step;
    logic [INCH_W-1:0] acc_q, acc_d, acc_step, acc_now;
    logic [INCH_W-1:0] inches_q, inches_d;
    logic              timeout_q, timeout_d;
    logic              valid_q, valid_d;
    logic              trig_q, ready_q;
    logic              us_tick, rise, fall, to_exit, ok_exit;

    // Free-running microsecond prescaler.
    assign us_tick = (psc_q == PSC_W'(CYC_PER_US - 1));

    // sync_q[1:0] is the 2-FF synchronizer, sync_q[2] the edge-detect copy.
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

    // One tick of the sub-inch/inch counters, saturating the inch count.
    always_comb begin
        sub_step = sub_q + 1'b1;
        acc_step = acc_q;
        if (sub_q == SUB_W'(US_PER_INCH - 1)) begin
            sub_step = '0;
            acc_step = (acc_q == INCH_MAX) ? acc_q : acc_q + 1'b1;
        end
        // The falling-edge cycle still counts its own tick, so the result
        // covers the full echo window.
        acc_now = us_tick ? acc_step : acc_q;
    end

`ifdef SONAR_AVG_EN
    logic [3:0][INCH_W-1:0] hist_q, hist_d;
    logic                   hist_full_q;
    logic [INCH_W+1:0]      sum;

    always_comb begin
        hist_d = hist_full_q ? {hist_q[2:0], acc_now} : {4{acc_now}};
        sum    = '0;
        for (int i = 0; i < 4; i++) sum = sum + {2'b00, hist_d[i]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q      <= '0;
            hist_full_q <= 1'b0;
        end else if (ok_exit) begin
            hist_q      <= hist_d;
            hist_full_q <= 1'b1;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        acc_d     = acc_q;
        inches_d  = inches_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        to_exit   = 1'b0;
        ok_exit   = 1'b0;
        case (state_q)
            IDLE: if (bus.do_measure) begin
                state_d = TRIG;
                cnt_d   = '0;
            end
            // Trigger width is counted in clocks, not ticks.
            TRIG: if (cnt_q == CNT_W'(TRIG_CYC - 1)) begin
                state_d = WAIT_RISE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            WAIT_RISE: if (rise) begin
                state_d = MEASURE;
                cnt_d   = '0;
                sub_d   = '0;
                acc_d   = '0;
            end else if (us_tick) begin
                if (cnt_q == CNT_W'(TIMEOUT_US - 1)) to_exit = 1'b1;
                else                                 cnt_d   = cnt_q + 1'b1;
            end
            // Echo fall takes priority over a coincident timeout.
            MEASURE: if (fall) begin
                ok_exit = 1'b1;
            end else if (us_tick) begin
                sub_d = sub_step;
                acc_d = acc_step;
                if (cnt_q == CNT_W'(TIMEOUT_US - 1)) to_exit = 1'b1;
                else                                 cnt_d   = cnt_q + 1'b1;
            end
            HOLDOFF: if (us_tick) begin
                if (cnt_q == CNT_W'(HOLDOFF_US - 1)) state_d = IDLE;
                else                                 cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (to_exit || ok_exit) begin
            state_d   = HOLDOFF;
            cnt_d     = '0;
            valid_d   = 1'b1;
            timeout_d = to_exit;
        end
        if (ok_exit) begin
`ifdef SONAR_AVG_EN
            inches_d = sum[INCH_W+1:2];
`else
            inches_d = acc_now;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            psc_q     <= '0;
            sync_q    <= '0;
            cnt_q     <= '0;
            sub_q     <= '0;
            acc_q     <= '0;
            inches_q  <= '0;
            timeout_q <= 1'b0;
            valid_q   <= 1'b0;
            trig_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_q     <= us_tick ? '0 : psc_q + 1'b1;
            sync_q    <= {sync_q[1:0], bus.sonar_pulse};
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            acc_q     <= acc_d;
            inches_q  <= inches_d;
            timeout_q <= timeout_d;
            valid_q   <= valid_d;
            trig_q    <= (state_d == TRIG);
            ready_q   <= (state_d == IDLE);
        end
    end

    assign bus.sonar_trigger = trig_q;
    assign bus.inches        = inches_q;
    assign bus.valid         = valid_q;
    assign bus.timeout       = timeout_q;
    assign bus.ready         = ready_q;
endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger with a scaled timebase (2 MHz clock,
// shortened timeout/holdoff) so the whole run stays short. Expected results
// are queued when each echo is driven and checked when valid strobes.
module tb_sonar_ranger;
    localparam int CLK_HZ      = 2_000_000;
    localparam int CYC         = CLK_HZ / 1_000_000;
    localparam int TRIG_US     = 10;
    localparam int US_PER_INCH = 148;
    localparam int TIMEOUT_US  = 6000;
    localparam int HOLDOFF_US  = 300;
    localparam int INCH_W      = 9;

    typedef struct {
        logic [INCH_W-1:0] inches;
        logic              to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sonar_ranger_if #(.INCH_W(INCH_W)) sif ();

    sonar_ranger #(
        .CLK_HZ(CLK_HZ), .TRIG_US(TRIG_US), .US_PER_INCH(US_PER_INCH),
        .TIMEOUT_US(TIMEOUT_US), .HOLDOFF_US(HOLDOFF_US), .INCH_W(INCH_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   n_valid  = 0;
    int   last_valid_cyc = 0;
    bit   has_prev = 1'b0;
    exp_t sb[$];

    logic [INCH_W-1:0] model_inches = '0;
    int                hist[4];
    bit                hist_full = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every valid strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (sif.valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("inches", 32'(sif.inches), 32'(e.inches));
                chk("timeout", 32'(sif.timeout), 32'(e.to));
            end
        end
    end

    task automatic model_reset();
        model_inches = '0;
        hist_full    = 1'b0;
        has_prev     = 1'b0;
    endtask

    // One full measurement: request, trigger, echo of width_us (0 = none).
    task automatic run_meas(input int delay_us, input int width_us);
        exp_t e;
        int   n, raw, t_fall, t_echo, base, gap;
        if (width_us == 0 || width_us >= TIMEOUT_US) begin
            e.to     = 1'b1;
            e.inches = model_inches;
        end else begin
            raw = width_us / US_PER_INCH;
            if (raw > (1 << INCH_W) - 1) raw = (1 << INCH_W) - 1;
`ifdef SONAR_AVG_EN
            if (!hist_full) for (int i = 0; i < 4; i++) hist[i] = raw;
            else begin
                for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = raw;
            end
            hist_full    = 1'b1;
            model_inches = INCH_W'((hist[0] + hist[1] + hist[2] + hist[3]) >> 2);
`else
            model_inches = INCH_W'(raw);
`endif
            e.to     = 1'b0;
            e.inches = model_inches;
        end
        sb.push_back(e);
        base = n_valid;

        sif.do_measure = 1'b1;
        n = 0;
        while (sif.sonar_trigger !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
        chk("trigger_rise", 32'(sif.sonar_trigger), 32'd1);
        sif.do_measure = 1'b0;
        if (has_prev) begin
            gap = cyc - last_valid_cyc;
            chk("holdoff_gap", 32'(gap >= HOLDOFF_US * CYC), 32'd1);
        end
        n = 0;
        while (sif.sonar_trigger === 1'b1 && n < 5000) begin @(negedge clk); n++; end
        chk("trigger_width", 32'(n), 32'(TRIG_US * CYC));
        t_fall = cyc;

        repeat (delay_us * CYC) @(negedge clk);
        t_echo = cyc;
        if (width_us > 0) begin
            sif.sonar_pulse = 1'b1;
            repeat (width_us * CYC) @(negedge clk);
            sif.sonar_pulse = 1'b0;
        end

        n = 0;
        while (n_valid == base && n < (TIMEOUT_US + 100) * CYC) begin @(negedge clk); n++; end
        chk("valid_count_step", 32'(n_valid - base), 32'd1);
        if (width_us == 0) begin
            gap = last_valid_cyc - t_fall;
            chk("noecho_timing", 32'(gap >= (TIMEOUT_US - 1) * CYC && gap <= (TIMEOUT_US + 1) * CYC), 32'd1);
        end else if (width_us >= TIMEOUT_US) begin
            gap = last_valid_cyc - t_echo;
            chk("stuck_timing", 32'(gap >= (TIMEOUT_US - 1) * CYC + 3 && gap <= (TIMEOUT_US + 1) * CYC + 3), 32'd1);
        end
        has_prev = 1'b1;
    endtask

    initial begin
        int n;
        sif.do_measure  = 1'b0;
        sif.sonar_pulse = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_ready", 32'(sif.ready), 32'd0);
        chk("rst_trigger", 32'(sif.sonar_trigger), 32'd0);
        chk("rst_inches", 32'(sif.inches), 32'd0);
        chk("rst_valid", 32'(sif.valid), 32'd0);
        chk("rst_timeout", 32'(sif.timeout), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(sif.ready), 32'd1);
        chk("post_rst_trigger", 32'(sif.sonar_trigger), 32'd0);
        chk("post_rst_inches", 32'(sif.inches), 32'd0);

        run_meas(200, 1480);   // 10 in
        run_meas(20, 0);       // no echo, holds 10
        run_meas(20, 1479);    // 9 in
        run_meas(20, 1628);    // 11 in
        run_meas(20, 6200);    // stuck echo, fall lands in holdoff

        repeat ((HOLDOFF_US + 10) * CYC) @(negedge clk);
        chk("idle_ready", 32'(sif.ready), 32'd1);

        // Reset during TRIG: trigger must drop without waiting for a clock.
        sif.do_measure = 1'b1;
        n = 0;
        while (sif.sonar_trigger !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        sif.do_measure = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_trigger_drop", 32'(sif.sonar_trigger), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset mid-MEASURE: aborted run must not produce a valid.
        sif.do_measure = 1'b1;
        n = 0;
        while (sif.sonar_trigger !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        sif.do_measure = 1'b0;
        n = 0;
        while (sif.sonar_trigger === 1'b1 && n < 100) begin @(negedge clk); n++; end
        repeat (20 * CYC) @(negedge clk);
        sif.sonar_pulse = 1'b1;
        repeat (300 * CYC) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_valid", 32'(sif.valid), 32'd0);
        chk("abort_ready", 32'(sif.ready), 32'd0);
        @(negedge clk);
        sif.sonar_pulse = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_inches", 32'(sif.inches), 32'd0);
        chk("abort_ready_back", 32'(sif.ready), 32'd1);
        model_reset();

        run_meas(20, 1480);    // 10
        run_meas(20, 2960);    // 20
        run_meas(20, 4440);    // 30
        run_meas(20, 5920);    // 40

        repeat (20) @(negedge clk);
        chk("total_valids", 32'(n_valid), 32'd9);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
